// File: rtl/gcd_iter.sv
// Sequential binary (Stein) GCD engine, one reduction step per clock, valid/ready on both sides.
// Optional CALC-cycle counter output `cycles` is built when GCD_ITER_CYCLES_EN is defined.
module gcd_iter #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(4*WIDTH+4)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef GCD_ITER_CYCLES_EN
  output logic [CW-1:0]    cycles,
`endif
  output logic [WIDTH-1:0] gcd_result
);

  localparam int KW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
  logic [KW-1:0]    k_q, k_d;
  logic             accept, finish;

  assign accept = (state_q == IDLE) && in_valid;
  assign finish = (state_q == CALC) && ((x_q == '0) || (y_q == '0));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (finish)    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
  end

  // One Stein step; rule order matters (zero checks before parity).
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    k_d   = k_q;
    res_d = res_q;
    if (accept) begin
      x_d = a;
      y_d = b;
      k_d = '0;
    end else if (state_q == CALC) begin
      if (x_q == '0) begin
        res_d = y_q << k_q;
      end else if (y_q == '0) begin
        res_d = x_q << k_q;
      end else if (!x_q[0] && !y_q[0]) begin
        x_d = x_q >> 1;
        y_d = y_q >> 1;
        k_d = k_q + KW'(1);
      end else if (!x_q[0]) begin
        x_d = x_q >> 1;
      end else if (!y_q[0]) begin
        y_d = y_q >> 1;
      end else if (x_q >= y_q) begin
        x_d = x_q - y_q;
      end else begin
        y_d = y_q - x_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      k_q   <= '0;
      res_q <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      k_q   <= k_d;
      res_q <= res_d;
    end
  end

  assign gcd_result = res_q;

`ifdef GCD_ITER_CYCLES_EN
  logic [CW-1:0] cnt_q, cnt_d, cyc_q, cyc_d;

  // The terminating CALC cycle is counted, hence +1 when latching.
  always_comb begin
    cnt_d = cnt_q;
    cyc_d = cyc_q;
    if (accept)                 cnt_d = '0;
    else if (state_q == CALC)   cnt_d = cnt_q + CW'(1);
    if (finish)                 cyc_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
    end
  end

  assign cycles = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_iter.sv
// Scoreboard bench for gcd_iter: 32-bit instance for directed/random traffic, 8-bit instance for extremes.
module tb_gcd_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, gcd_result;
`ifdef GCD_ITER_CYCLES_EN
  logic [7:0]  cycles;
  logic [5:0]  cycles8;
`endif
  logic        iv8, ir8, ov8, or8;
  logic [7:0]  a8, b8, res8;

  int          n_chk = 0;
  int          n_bad = 0;
  int          ordy_mode = 0;  // 0: ready high, 1: ready low, 2: random
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  gcd_iter #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef GCD_ITER_CYCLES_EN
    .cycles(cycles),
`endif
    .gcd_result(gcd_result));

  gcd_iter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
`ifdef GCD_ITER_CYCLES_EN
    .cycles(cycles8),
`endif
    .gcd_result(res8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // out_ready driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ordy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Result monitor: handshake seen at negedge completes on the next rising edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_result", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("result", gcd_result, e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input bit push);
    int t = 0;
    @(posedge clk); #1;
    a = av; b = bv; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 400) begin
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    if (push) exp_q.push_back(ref_gcd(av, bv));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;  // must not disturb the running op
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ev);
    int t = 0;
    while (!ir8 && t < 100) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    a8 = av; b8 = bv; iv8 = 1'b1;
    @(negedge clk);
    chk("w8_ready", ir8, 1);
    @(posedge clk); #1;
    iv8 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
    t = 1;
    while (!ov8 && t <= 34) begin @(posedge clk); #1; t++; end
    chk("w8_within_34", ov8, 1);
    chk("w8_result", res8, ev);
    @(posedge clk); #1;
  endtask

  logic [31:0] dir_a[11] = '{90, 48, 65, 48, 8, 125, 85, 54, 95, 109, 75};
  logic [31:0] dir_b[11] = '{86, 12,  4,  7, 2,   6, 76, 44, 32,  91, 34};

  initial begin
    int seen;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", gcd_result, 0);
`ifdef GCD_ITER_CYCLES_EN
    chk("rst_cycles", cycles, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    // Directed pairs
    ordy_mode = 0;
    for (int i = 0; i < 11; i++) issue(dir_a[i], dir_b[i], 1'b1);
    drain();
    issue(48, 12, 1'b1);
    drain();
`ifdef GCD_ITER_CYCLES_EN
    chk("cycles_48_12", cycles, 6);
`endif

    // Zero operands
    issue(0, 17, 1'b1); drain();
`ifdef GCD_ITER_CYCLES_EN
    chk("cycles_0_17", cycles, 1);
`endif
    issue(23, 0, 1'b1); drain();
`ifdef GCD_ITER_CYCLES_EN
    chk("cycles_23_0", cycles, 1);
`endif
    issue(0, 0, 1'b1); drain();
`ifdef GCD_ITER_CYCLES_EN
    chk("cycles_0_0", cycles, 1);
`endif

    // Back-pressure
    ordy_mode = 1;
    @(posedge clk);
    issue(48, 12, 1'b1);
    seen = 0;
    while (!out_valid && seen < 200) begin @(negedge clk); seen++; end
    chk("bp_valid_rise", out_valid, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", gcd_result, 12);
      chk("bp_in_ready", in_ready, 0);
    end
    ordy_mode = 0;
    drain();
    @(posedge clk); #1;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_valid", out_valid, 0);

    // Reset mid-CALC
    issue(1000000007, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_result", gcd_result, 0);
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_result", seen, 0);
    issue(100, 75, 1'b1);
    drain();

    // Extremes on the 8-bit instance
    run8(255, 1, 1);
    run8(128, 128, 128);

    // Random traffic with random out_ready
    ordy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      case ($urandom_range(0, 3))
        0: begin ra = $urandom_range(0, 255) * 36; rb = $urandom_range(0, 255) * 60; end
        1: begin ra = $urandom_range(0, 3);        rb = $urandom; end
        default: begin ra = $urandom;              rb = $urandom; end
      endcase
      issue(ra, rb, 1'b1);
    end
    drain();
    ordy_mode = 0;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
